// File: rtl/clkgate_ctrl.sv
// Clock-gate sequencer: opens the gate on request, grants after a wake delay, closes after idle hysteresis.
// Optional gated-cycle statistics counter enabled by defining CLKGATE_CTRL_STATS_EN.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_OFF  | gate closed, waiting for any request
// S_WAKE | gate open, letting the gated clock settle; no grants yet
// S_ON   | gate open and stable; active requesters are acknowledged
// S_IDLE | gate still open, counting down hysteresis before closing
module clkgate_ctrl #(
    parameter int NREQ        = 4,
    parameter int WAKE_CYCLES = 2,
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NREQ-1:0]  req_i,
    output logic [NREQ-1:0]  ack_o,
    input  logic             test_en_i,
    output logic             en_o,
    output logic             busy_o,
    output logic [CNT_W-1:0] gated_cycles_o
);

    localparam int WW = $clog2(WAKE_CYCLES) + 1;
    localparam int IW = $clog2(IDLE_CYCLES) + 1;
    localparam logic [WW-1:0] WAKE_LOAD = WW'(WAKE_CYCLES - 1);
    localparam logic [IW-1:0] IDLE_LOAD = IW'(IDLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_WAKE = 2'd1,
        S_ON   = 2'd2,
        S_IDLE = 2'd3
    } state_t;

    state_t        state_q;
    logic          en_q;
    logic          busy_q;
    logic [WW-1:0] wake_cnt_q;
    logic [IW-1:0] idle_cnt_q;
    logic          any_req;

    assign any_req = |req_i;

    // Down-counters are loaded on state entry and leave the state at zero, so they never wrap.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_OFF;
            en_q       <= 1'b0;
            busy_q     <= 1'b0;
            wake_cnt_q <= '0;
            idle_cnt_q <= '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (any_req) begin
                        state_q    <= S_WAKE;
                        en_q       <= 1'b1;
                        busy_q     <= 1'b1;
                        wake_cnt_q <= WAKE_LOAD;
                    end
                end
                S_WAKE: begin
                    if (wake_cnt_q == '0) begin
                        state_q <= S_ON;
                    end else begin
                        wake_cnt_q <= wake_cnt_q - 1'b1;
                    end
                end
                S_ON: begin
                    if (!any_req) begin
                        state_q    <= S_IDLE;
                        idle_cnt_q <= IDLE_LOAD;
                    end
                end
                S_IDLE: begin
                    // A request in the final idle cycle still wins over closing.
                    if (any_req) begin
                        state_q <= S_ON;
                    end else if (idle_cnt_q == '0) begin
                        state_q <= S_OFF;
                        en_q    <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        idle_cnt_q <= idle_cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= S_OFF;
                    en_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign ack_o  = req_i & {NREQ{state_q == S_ON}};
    assign en_o   = en_q | test_en_i;
    assign busy_o = busy_q;

`ifdef CLKGATE_CTRL_STATS_EN
    logic [CNT_W-1:0] gated_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            gated_q <= '0;
        end else if (!en_o && (gated_q != {CNT_W{1'b1}})) begin
            gated_q <= gated_q + 1'b1;
        end
    end

    assign gated_cycles_o = gated_q;
`else
    assign gated_cycles_o = '0;
`endif

endmodule

// File: tb/tb_clkgate_ctrl.sv
// Directed bench for clkgate_ctrl (WAKE_CYCLES=2, IDLE_CYCLES=16, CNT_W=4).
// Statistics expectations follow CLKGATE_CTRL_STATS_EN.
module tb_clkgate_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b1;
    logic [3:0] req_i = 4'b0000;
    logic [3:0] ack_o;
    logic       test_en_i = 1'b0;
    logic       en_o;
    logic       busy_o;
    logic [3:0] gated_cycles_o;

    int checks = 0;
    int errors = 0;

    clkgate_ctrl #(
        .NREQ(4),
        .WAKE_CYCLES(2),
        .IDLE_CYCLES(16),
        .CNT_W(4)
    ) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .req_i(req_i),
        .ack_o(ack_o),
        .test_en_i(test_en_i),
        .en_o(en_o),
        .busy_o(busy_o),
        .gated_cycles_o(gated_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance one clock; returns 2 time units after the rising edge.
    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_i);
            #2;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        rst_i = 1'b1;
        cyc(2);
        chk("rst_en", en_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_ack", ack_o, 0);
        chk("rst_gated", gated_cycles_o, 0);
        test_en_i = 1'b1;
        #1;
        chk("rst_test_en", en_o, 1);
        test_en_i = 1'b0;
        rst_i = 1'b0;
        cyc(1);
        chk("post_rst_en", en_o, 0);
        chk("post_rst_busy", busy_o, 0);

        // Wake latency: request in cycle t, en at t+1, ack at t+3
        req_i = 4'b0001;
        cyc(1);
        chk("wake_en", en_o, 1);
        chk("wake_busy", busy_o, 1);
        chk("wake_ack_t1", ack_o, 0);
        cyc(1);
        chk("wake_ack_t2", ack_o, 0);
        cyc(1);
        chk("wake_ack_t3", ack_o, 4'b0001);

        // Multiple requesters
        req_i = 4'b1010;
        #1;
        chk("multi_ack", ack_o, 4'b1010);
        cyc(1);
        req_i = 4'b1000;
        #1;
        chk("multi_drop_ack", ack_o, 4'b1000);
        cyc(1);
        chk("multi_stay_on", ack_o, 4'b1000);
        chk("multi_busy", busy_o, 1);

        // Idle close: drop at t, IDLE at t+1, OFF at t+17
        req_i = 4'b0000;
        #1;
        chk("drop_ack", ack_o, 0);
        cyc(1);
        chk("idle_en", en_o, 1);
        chk("idle_ack", ack_o, 0);
        cyc(15);
        chk("idle_last_en", en_o, 1);
        chk("idle_last_busy", busy_o, 1);
        cyc(1);
        chk("close_en", en_o, 0);
        chk("close_busy", busy_o, 0);

        // Re-request in the 16th IDLE cycle
        req_i = 4'b0001;
        cyc(3);
        chk("rereq_on_ack", ack_o, 4'b0001);
        req_i = 4'b0000;
        cyc(16);
        chk("rereq_idle16_en", en_o, 1);
        req_i = 4'b0001;
        #1;
        chk("rereq_idle16_ack", ack_o, 0);
        cyc(1);
        chk("rereq_on_en", en_o, 1);
        chk("rereq_on_ack2", ack_o, 4'b0001);
        cyc(1);
        chk("rereq_hold_en", en_o, 1);

        // Back to OFF, then DFT override
        req_i = 4'b0000;
        cyc(17);
        chk("off_again_busy", busy_o, 0);
        test_en_i = 1'b1;
        #1;
        chk("test_en_en", en_o, 1);
        chk("test_en_ack", ack_o, 0);
        cyc(1);
        chk("test_en_busy", busy_o, 0);
        test_en_i = 1'b0;
        #1;
        chk("test_en_off_en", en_o, 0);

        // Reset mid-WAKE, then held request restarts the full wake
        req_i = 4'b0001;
        cyc(1);
        chk("midwake_busy", busy_o, 1);
        rst_i = 1'b1;
        cyc(1);
        chk("midwake_rst_en", en_o, 0);
        chk("midwake_rst_busy", busy_o, 0);
        chk("midwake_rst_ack", ack_o, 0);
        rst_i = 1'b0;
        cyc(1);
        chk("restart_en", en_o, 1);
        chk("restart_ack1", ack_o, 0);
        cyc(1);
        chk("restart_ack2", ack_o, 0);
        cyc(1);
        chk("restart_ack3", ack_o, 4'b0001);

        // Reset mid-ON aborts the grant
        rst_i = 1'b1;
        cyc(1);
        chk("midon_rst_ack", ack_o, 0);
        chk("midon_rst_busy", busy_o, 0);

        // Statistics: closed cycles after reset release
        req_i = 4'b0000;
        cyc(1);
        chk("stats_rst", gated_cycles_o, 0);
        rst_i = 1'b0;
        cyc(5);
`ifdef CLKGATE_CTRL_STATS_EN
        chk("stats_5", gated_cycles_o, 5);
`else
        chk("stats_5", gated_cycles_o, 0);
`endif
        cyc(15);
`ifdef CLKGATE_CTRL_STATS_EN
        chk("stats_sat", gated_cycles_o, 4'hF);
`else
        chk("stats_sat", gated_cycles_o, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
